// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad time-entry block: FSM states,
// special key codes and BCD helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_START     = 4'd10;
    localparam logic [3:0] KEY_CANCEL    = 4'd11;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    function automatic logic [3:0] bcd_tens(input int unsigned v);
        return 4'((v / 10) % 10);
    endfunction

    function automatic logic [3:0] bcd_ones(input int unsigned v);
        return 4'(v % 10);
    endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Key/door/timer inputs and digit/strobe outputs of the time-entry block.
interface keypad_time_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_closed;
    logic       timer_busy;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       entry_active;
    logic       load_pulse;
    logic       invalid_pulse;
    logic       abort_pulse;

    // Drives keys and status, observes the entered time.
    modport master (
        output key_valid, key_code, door_closed, timer_busy,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_count,
        input  entry_active, load_pulse, invalid_pulse, abort_pulse
    );

    // The time-entry block itself.
    modport slave (
        input  key_valid, key_code, door_closed, timer_busy,
        output min_tens, min_ones, sec_tens, sec_ones, digit_count,
        output entry_active, load_pulse, invalid_pulse, abort_pulse
    );
endinterface

// File: rtl/key_edge_detect.sv
// One-cycle edge detector on a level input. FALL = 0 flags a rising edge,
// FALL = 1 flags a falling edge. The event is combinational so that the
// consumer acts on the same clock edge that samples the new level.
module key_edge_detect #(
    parameter bit FALL = 1'b0
) (
    input  logic clock,
    input  logic clear_n,
    input  logic level,
    output logic ev
);

    logic level_q;
    logic level_d;

    // Next value of the delayed level is simply the current level.
    always_comb begin
        level_d = level;
    end

    // Delay the level by one clock to compare against.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) level_q <= 1'b0;
        else          level_q <= level_d;
    end

    assign ev = FALL ? (level_q & ~level) : (level & ~level_q);

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: shifts in up to NUM_DIGITS BCD digits as MM:SS,
// validates on START, strobes a load to the countdown timer and then
// locks entry until the timer finishes or the user cancels.
module keypad_time_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int QUICK_SECONDS = 30
) (
    input  logic clock,
    input  logic clear_n,
    keypad_time_entry_if.slave kp
);

    localparam logic [2:0] MAX_COUNT  = 3'(NUM_DIGITS);
    localparam logic [3:0] QUICK_TENS = bcd_tens(QUICK_SECONDS);
    localparam logic [3:0] QUICK_ONES = bcd_ones(QUICK_SECONDS);

    logic key_ev;
    logic busy_fall;

    key_edge_detect #(.FALL(1'b0)) u_key_edge (
        .clock   (clock),
        .clear_n (clear_n),
        .level   (kp.key_valid),
        .ev      (key_ev)
    );

    key_edge_detect #(.FALL(1'b1)) u_busy_edge (
        .clock   (clock),
        .clear_n (clear_n),
        .level   (kp.timer_busy),
        .ev      (busy_fall)
    );

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
    logic [2:0] digit_count_q, digit_count_d;
    logic       entry_active_q, entry_active_d;
    logic       load_pulse_q, load_pulse_d;
    logic       invalid_pulse_q, invalid_pulse_d;
    logic       abort_pulse_q, abort_pulse_d;

    logic is_digit, is_start, is_cancel;

    assign is_digit  = key_ev && (kp.key_code <= KEY_DIGIT_MAX);
    assign is_start  = key_ev && (kp.key_code == KEY_START);
    assign is_cancel = key_ev && (kp.key_code == KEY_CANCEL);

    // Next-state, shift chain and strobe decode for the entry FSM.
    always_comb begin
        state_d         = state_q;
        min_tens_d      = min_tens_q;
        min_ones_d      = min_ones_q;
        sec_tens_d      = sec_tens_q;
        sec_ones_d      = sec_ones_q;
        digit_count_d   = digit_count_q;
        invalid_pulse_d = 1'b0;
        abort_pulse_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_digit) begin
                    min_tens_d    = min_ones_q;
                    min_ones_d    = sec_tens_q;
                    sec_tens_d    = sec_ones_q;
                    sec_ones_d    = kp.key_code;
                    digit_count_d = 3'd1;
                    state_d       = ST_ENTRY;
                end else if (is_start) begin
                    if (kp.door_closed) begin
                        min_tens_d = 4'd0;
                        min_ones_d = 4'd0;
                        sec_tens_d = QUICK_TENS;
                        sec_ones_d = QUICK_ONES;
                        state_d    = ST_LOAD;
                    end else begin
                        invalid_pulse_d = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                if (is_digit) begin
                    if (digit_count_q < MAX_COUNT) begin
                        min_tens_d    = min_ones_q;
                        min_ones_d    = sec_tens_q;
                        sec_tens_d    = sec_ones_q;
                        sec_ones_d    = kp.key_code;
                        digit_count_d = digit_count_q + 3'd1;
                    end
                end else if (is_start) begin
                    if (kp.door_closed && (sec_tens_q <= SEC_TENS_MAX)) begin
                        state_d = ST_LOAD;
                    end else begin
                        invalid_pulse_d = 1'b1;
                    end
                end else if (is_cancel) begin
                    min_tens_d    = 4'd0;
                    min_ones_d    = 4'd0;
                    sec_tens_d    = 4'd0;
                    sec_ones_d    = 4'd0;
                    digit_count_d = 3'd0;
                    state_d       = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Key events arriving while the load strobe is out are dropped.
                state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                // CANCEL takes priority over a coincident end of countdown.
                if (is_cancel || busy_fall) begin
                    abort_pulse_d = is_cancel;
                    min_tens_d    = 4'd0;
                    min_ones_d    = 4'd0;
                    sec_tens_d    = 4'd0;
                    sec_ones_d    = 4'd0;
                    digit_count_d = 3'd0;
                    state_d       = ST_IDLE;
                end
            end
        endcase

        entry_active_d = (state_d == ST_ENTRY);
        load_pulse_d   = (state_d == ST_LOAD);
    end

    // State, digit and registered-output flops.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q         <= ST_IDLE;
            min_tens_q      <= 4'd0;
            min_ones_q      <= 4'd0;
            sec_tens_q      <= 4'd0;
            sec_ones_q      <= 4'd0;
            digit_count_q   <= 3'd0;
            entry_active_q  <= 1'b0;
            load_pulse_q    <= 1'b0;
            invalid_pulse_q <= 1'b0;
            abort_pulse_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            min_tens_q      <= min_tens_d;
            min_ones_q      <= min_ones_d;
            sec_tens_q      <= sec_tens_d;
            sec_ones_q      <= sec_ones_d;
            digit_count_q   <= digit_count_d;
            entry_active_q  <= entry_active_d;
            load_pulse_q    <= load_pulse_d;
            invalid_pulse_q <= invalid_pulse_d;
            abort_pulse_q   <= abort_pulse_d;
        end
    end

    assign kp.min_tens      = min_tens_q;
    assign kp.min_ones      = min_ones_q;
    assign kp.sec_tens      = sec_tens_q;
    assign kp.sec_ones      = sec_ones_q;
    assign kp.digit_count   = digit_count_q;
    assign kp.entry_active  = entry_active_q;
    assign kp.load_pulse    = load_pulse_q;
    assign kp.invalid_pulse = invalid_pulse_q;
    assign kp.abort_pulse   = abort_pulse_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry.
module tb_keypad_time_entry;

    logic clock;
    logic clear_n;
    int   n_tests;
    int   n_fail;
    int   n_load;
    int   n_inv;
    int   n_abort;
    logic [15:0] load_val;

    keypad_time_entry_if kp ();

    keypad_time_entry #(.NUM_DIGITS(4), .QUICK_SECONDS(30)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .kp      (kp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count strobes once per cycle, away from the active edge.
    always @(negedge clock) begin
        if (kp.load_pulse) begin
            n_load++;
            load_val = {kp.min_tens, kp.min_ones, kp.sec_tens, kp.sec_ones};
        end
        if (kp.invalid_pulse) n_inv++;
        if (kp.abort_pulse)   n_abort++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_load   = 0;
        n_inv    = 0;
        n_abort  = 0;
        load_val = 16'h0;
    endtask

    // One press: key_valid high for one full cycle, then low for one.
    task automatic press(input logic [3:0] c);
        @(negedge clock);
        kp.key_code  = c;
        kp.key_valid = 1'b1;
        @(negedge clock);
        kp.key_valid = 1'b0;
        @(negedge clock);
        #1;
    endtask

    function automatic logic [15:0] digits();
        return {kp.min_tens, kp.min_ones, kp.sec_tens, kp.sec_ones};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_counts();
        clear_n        = 1'b0;
        kp.key_valid   = 1'b0;
        kp.key_code    = 4'd0;
        kp.door_closed = 1'b1;
        kp.timer_busy  = 1'b0;

        #12;
        check("rst_digits", 32'(digits()), 32'h0);
        check("rst_count",  32'(kp.digit_count), 32'd0);
        check("rst_flags",  32'({kp.entry_active, kp.load_pulse, kp.invalid_pulse, kp.abort_pulse}), 32'h0);
        @(negedge clock);
        clear_n = 1'b1;

        // Entry 1,2,3,0 then START -> 12:30 load, locked.
        press(4'd1);
        check("e1_digits", 32'(digits()), 32'h0001);
        check("e1_active", 32'(kp.entry_active), 32'd1);
        press(4'd2);
        check("e2_digits", 32'(digits()), 32'h0012);
        press(4'd3);
        check("e3_digits", 32'(digits()), 32'h0123);
        press(4'd0);
        check("e4_digits", 32'(digits()), 32'h1230);
        check("e4_count",  32'(kp.digit_count), 32'd4);
        clear_counts();
        press(4'd10);
        check("ld_count",  32'(n_load), 32'd1);
        check("ld_value",  32'(load_val), 32'h1230);
        check("ld_inv",    32'(n_inv), 32'd0);
        check("ld_active", 32'(kp.entry_active), 32'd0);
        press(4'd5);
        press(4'd10);
        check("lock_digits", 32'(digits()), 32'h1230);
        check("lock_noload", 32'(n_load), 32'd1);
        // Countdown runs then finishes -> back to IDLE, no abort.
        @(negedge clock); kp.timer_busy = 1'b1;
        repeat (3) @(negedge clock);
        kp.timer_busy = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("done_digits", 32'(digits()), 32'h0);
        check("done_count",  32'(kp.digit_count), 32'd0);
        check("done_abort",  32'(n_abort), 32'd0);

        // Five digits: fifth is ignored.
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
        check("five_digits", 32'(digits()), 32'h9876);
        check("five_count",  32'(kp.digit_count), 32'd4);
        press(4'd11);
        check("cxl1_digits", 32'(digits()), 32'h0);
        check("cxl1_active", 32'(kp.entry_active), 32'd0);

        // sec_tens = 7 -> rejected START, digits kept.
        press(4'd0); press(4'd1); press(4'd7); press(4'd0);
        clear_counts();
        press(4'd10);
        check("bad_inv",    32'(n_inv), 32'd1);
        check("bad_load",   32'(n_load), 32'd0);
        check("bad_digits", 32'(digits()), 32'h0170);
        check("bad_active", 32'(kp.entry_active), 32'd1);
        press(4'd11);
        check("cxl2_digits", 32'(digits()), 32'h0);
        check("cxl2_count",  32'(kp.digit_count), 32'd0);
        check("cxl2_active", 32'(kp.entry_active), 32'd0);

        // Quick start: door open rejected, door closed loads 00:30.
        clear_counts();
        kp.door_closed = 1'b0;
        press(4'd10);
        check("qs_open_inv",  32'(n_inv), 32'd1);
        check("qs_open_load", 32'(n_load), 32'd0);
        kp.door_closed = 1'b1;
        press(4'd10);
        check("qs_load",  32'(n_load), 32'd1);
        check("qs_value", 32'(load_val), 32'h0030);

        // LOCKED: CANCEL coincident with timer_busy falling -> abort once.
        @(negedge clock); kp.timer_busy = 1'b1;
        repeat (2) @(negedge clock);
        clear_counts();
        kp.key_code   = 4'd11;
        kp.key_valid  = 1'b1;
        kp.timer_busy = 1'b0;
        @(negedge clock);
        kp.key_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("both_abort",  32'(n_abort), 32'd1);
        check("both_digits", 32'(digits()), 32'h0);
        check("both_active", 32'(kp.entry_active), 32'd0);

        // Held key: one shift-in only.
        @(negedge clock);
        kp.key_code  = 4'd4;
        kp.key_valid = 1'b1;
        repeat (20) @(negedge clock);
        kp.key_valid = 1'b0;
        @(negedge clock);
        #1;
        check("hold_count",  32'(kp.digit_count), 32'd1);
        check("hold_digits", 32'(digits()), 32'h0004);

        // Async reset in the middle of entry.
        press(4'd5);
        check("pre_rst_digits", 32'(digits()), 32'h0045);
        clear_counts();
        @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        check("mid_rst_digits", 32'(digits()), 32'h0);
        check("mid_rst_count",  32'(kp.digit_count), 32'd0);
        check("mid_rst_active", 32'(kp.entry_active), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        check("mid_rst_pulses", 32'(n_load + n_inv + n_abort), 32'd0);
        press(4'd7);
        check("post_rst_digits", 32'(digits()), 32'h0007);
        check("post_rst_count",  32'(kp.digit_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Downstream consumer of the debounced key-edge stage in timer_input_control.
- Detects each new debounced keypress and decodes the latched key code.
- Builds a 4-digit MM:SS BCD cooking time by shift-in, and validates the time on START.
- Issues a one-cycle load strobe to the countdown timer, then locks entry while the countdown runs.

Parameters:
- NUM_DIGITS, 4, maximum digits accepted; also the width of the BCD shift chain.
- QUICK_SECONDS, 30, seconds loaded when START is pressed with no digits entered (range 0-59).

Ports:
- clock  input  1  system clock, rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- key_valid  input  1  debounced key-valid level; goes high once per press, low between presses.
- key_code  input  4  key code, stable while key_valid is high: 0-9 = digit, 10 = START, 11 = CANCEL, 12-15 = ignored.
- door_closed  input  1  1 = door closed; START is permitted only when 1.
- timer_busy  input  1  countdown-running level from the timer.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  entered BCD digits.
- digit_count  output  3  number of digits entered, 0..NUM_DIGITS.
- entry_active  output  1  1 in ENTRY state.
- load_pulse  output  1  one-cycle strobe; the digit outputs are valid load data in that cycle.
- invalid_pulse  output  1  one-cycle strobe on a rejected START.
- abort_pulse  output  1  one-cycle strobe on CANCEL while LOCKED.

Behaviour:
- Reset (clear_n = 0, asynchronous):
  - All digit outputs = 0; digit_count = 0.
  - All pulse outputs = 0; entry_active = 0.
  - State = IDLE; key_valid_q = 0; busy_q = 0.
- Key event: ev = key_valid & ~key_valid_q, evaluated at a rising clock edge.
  - Exactly one action per press; holding key_valid high produces no repeats.
  - All resulting register and output updates take effect at that same edge (0 extra latency).
- FSM states: IDLE, ENTRY, LOAD, LOCKED.
- IDLE:
  - Digit d: shift in, digit_count = 1, go to ENTRY.
  - START with door_closed = 1: load 00:QUICK_SECONDS (BCD), go to LOAD.
  - START with door_closed = 0: invalid_pulse.
  - CANCEL and codes 12-15: no effect.
- ENTRY:
  - Digit with digit_count < NUM_DIGITS: shift left one digit position (min_tens <= min_ones <= sec_tens <= sec_ones <= d); digit_count + 1.
  - Digit with digit_count = NUM_DIGITS: ignored; count saturates at 4.
  - START, door_closed = 1 and sec_tens <= 5: go to LOAD.
  - START, door open or sec_tens > 5: invalid_pulse; digits retained; stay in ENTRY.
  - CANCEL: clear digits and count, go to IDLE.
- LOAD:
  - Single cycle; load_pulse = 1; go to LOCKED.
  - Any key event in this cycle is dropped.
- LOCKED:
  - Digits and START are ignored; digits hold the loaded value.
  - CANCEL: abort_pulse, clear digits, go to IDLE.
  - Falling edge of timer_busy (busy_q = 1 and timer_busy = 0): clear digits, go to IDLE.
  - If timer_busy never rises, the block remains LOCKED until CANCEL.
- Pulses are registered and high for exactly one cycle. At most one pulse fires per cycle.
- Simultaneous CANCEL event and timer_busy fall in LOCKED: CANCEL wins (abort_pulse = 1), then go to IDLE.
- Reset mid-entry or mid-LOCKED: immediate return to reset values; no pulse is emitted.
- Digit value 0 counts as a digit (leading zeros increment digit_count).

Decomposition:
- Shared package keypad_pkg holds:
  - State encoding constants (2-bit): ST_IDLE = 0, ST_ENTRY = 1, ST_LOAD = 2, ST_LOCKED = 3.
  - Key code constants: KEY_START = 10, KEY_CANCEL = 11.
  - BCD limit constant: SEC_TENS_MAX = 5.
- One sub-module, key_edge_detect: registers key_valid and outputs the one-cycle ev. The same cell, with an inverted sense, is reused for the timer_busy fall.
- FSM and shift chain stay in keypad_time_entry.

Test Plan:
- Keys 1,2,3,0, then START, door closed -> digits 0,1,2,3 → 1,2,3,0 progression; load_pulse one cycle with MM:SS = 12:30; state LOCKED.
- Five digits 9,8,7,6,5 -> digits 9,8,7,6; digit_count = 4; the 5th key is ignored.
- Entry 0,1,7,0 then START -> sec_tens = 7 > 5 gives invalid_pulse, no load_pulse, digits retained; then CANCEL -> all 0, IDLE.
- START from IDLE with door open -> invalid_pulse; with door closed -> load_pulse with 00:30.
- key_valid held high 20 cycles with code 4 -> exactly one shift-in; digit_count = 1.
- LOCKED, timer_busy 1 → 0 in the same cycle as a CANCEL event -> abort_pulse = 1 once, IDLE, digits 0. Also assert clear_n low mid-ENTRY -> immediate reset values, no pulses.
